// File: rtl/experiment_sequencer.sv
// Run-level sequencer for the single-shot experiment FSM: start/release/cooldown per shot,
// watchdog recovery of a hung FSM, and shot/failure accounting. Optional macro: RETRY_EN.
module experiment_sequencer #(
   parameter int CNT_W      = 16,
   parameter int FIN_CODE   = 8,
   parameter int RESET_HOLD = 4,
   parameter int MAX_RETRY  = 3
) (
   input  logic             clock,
   input  logic             reset_signal,
   input  logic             arm,
   input  logic             abort,
   input  logic [CNT_W-1:0] shot_count,
   input  logic [31:0]      cooldown,
   input  logic [31:0]      watchdog,
   input  logic [7:0]       fsm_state,
   output logic             fsm_start,
   output logic             fsm_reset,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] shots_done,
   output logic [CNT_W-1:0] fail_count,
   output logic [2:0]       seq_state
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_START    = 3'd1,
      ST_RUN      = 3'd2,
      ST_RELEASE  = 3'd3,
      ST_COOLDOWN = 3'd4,
      ST_RECOVER  = 3'd5,
      ST_DONE     = 3'd6
   } state_t;

   localparam logic [7:0]  FIN_STATE = 8'(FIN_CODE);
   localparam logic [31:0] HOLD_LAST = 32'(RESET_HOLD - 1);
   localparam logic [31:0] TMR_MAX   = 32'hFFFF_FFFF;

   if (RESET_HOLD < 2 || MAX_RETRY < 1) begin : g_bad_cfg
      $error("experiment_sequencer: RESET_HOLD must be >= 2 and MAX_RETRY >= 1");
   end

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         return v;
      end else begin
         return v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

   state_t           state_r, next_state_s;
   logic [CNT_W-1:0] shot_cfg_r, shots_done_r, fail_count_r;
   logic [31:0]      cd_lim_r, wd_lim_r, tmr_r;
   logic             abort_r, error_r;
   logic             fsm_start_r, fsm_reset_r, busy_r, done_r;
   logic             cfg_load_s, shot_ok_s, shot_fail_s, abort_go_s;
   logic             wd_hit_s, cd_end_s, hold_end_s, target_s, tmr_clr_s;
   logic             recover_to_done_s, consume_s;

   // One timer serves as watchdog (START..RELEASE), cooldown and reset-hold counter.
   assign wd_hit_s   = (wd_lim_r != 32'd0) && (tmr_r >= (wd_lim_r - 32'd1));
   assign cd_end_s   = (cd_lim_r == 32'd0) || (tmr_r >= (cd_lim_r - 32'd1));
   assign hold_end_s = (tmr_r >= HOLD_LAST);
   assign target_s   = (shots_done_r == shot_cfg_r);
   assign tmr_clr_s  = (next_state_s != state_r) &&
                       ((next_state_s == ST_START) || (next_state_s == ST_COOLDOWN) ||
                        (next_state_s == ST_RECOVER));

`ifdef RETRY_EN
   localparam int              RTY_W     = $clog2(MAX_RETRY + 2);
   localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRY);
   localparam logic [RTY_W-1:0] RTY_ONE   = RTY_W'(1);
   logic [RTY_W-1:0] retry_r;

   assign recover_to_done_s = (retry_r > RTY_LIMIT);
   assign consume_s         = shot_ok_s;

   // Consecutive-failure count for the current shot; a finished shot clears it.
   always_ff @(posedge clock) begin
      if (!reset_signal) begin
         retry_r <= {RTY_W{1'b0}};
      end else if (cfg_load_s || shot_ok_s) begin
         retry_r <= {RTY_W{1'b0}};
      end else if (shot_fail_s && (retry_r <= RTY_LIMIT)) begin
         retry_r <= retry_r + RTY_ONE;
      end else begin
         retry_r <= retry_r;
      end
   end
`else
   assign recover_to_done_s = target_s;
   assign consume_s         = shot_ok_s | shot_fail_s;
`endif

   // Next-state selection and per-cycle event strobes; abort outranks every other event.
   always_comb begin
      next_state_s = state_r;
      cfg_load_s   = 1'b0;
      shot_ok_s    = 1'b0;
      shot_fail_s  = 1'b0;
      abort_go_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (arm) begin
               if (shot_count != {CNT_W{1'b0}}) begin
                  cfg_load_s   = 1'b1;
                  next_state_s = ST_START;
               end else begin
                  next_state_s = ST_DONE;
               end
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (abort) begin
               abort_go_s   = 1'b1;
               next_state_s = ST_RECOVER;
            end else if (fsm_state != 8'd0) begin
               next_state_s = ST_RUN;
            end else if (wd_hit_s) begin
               shot_fail_s  = 1'b1;
               next_state_s = ST_RECOVER;
            end else begin
               next_state_s = ST_START;
            end
         end
         ST_RUN: begin
            if (abort) begin
               abort_go_s   = 1'b1;
               next_state_s = ST_RECOVER;
            end else if (fsm_state == FIN_STATE) begin
               shot_ok_s    = 1'b1;
               next_state_s = ST_RELEASE;
            end else if (wd_hit_s) begin
               shot_fail_s  = 1'b1;
               next_state_s = ST_RECOVER;
            end else begin
               next_state_s = ST_RUN;
            end
         end
         ST_RELEASE: begin
            if (abort) begin
               abort_go_s   = 1'b1;
               next_state_s = ST_RECOVER;
            end else if (fsm_state == 8'd0) begin
               if (target_s) begin
                  next_state_s = ST_DONE;
               end else begin
                  next_state_s = ST_COOLDOWN;
               end
            end else if (wd_hit_s) begin
               shot_fail_s  = 1'b1;
               next_state_s = ST_RECOVER;
            end else begin
               next_state_s = ST_RELEASE;
            end
         end
         ST_COOLDOWN: begin
            if (abort) begin
               abort_go_s   = 1'b1;
               next_state_s = ST_RECOVER;
            end else if (cd_end_s) begin
               next_state_s = ST_START;
            end else begin
               next_state_s = ST_COOLDOWN;
            end
         end
         ST_RECOVER: begin
            if (hold_end_s) begin
               if (abort || abort_r || recover_to_done_s) begin
                  next_state_s = ST_DONE;
               end else begin
                  next_state_s = ST_COOLDOWN;
               end
            end else begin
               next_state_s = ST_RECOVER;
            end
         end
         ST_DONE: begin
            next_state_s = ST_IDLE;
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // State, shared timer, abort flavour of RECOVER, and registered status outputs.
   always_ff @(posedge clock) begin
      if (!reset_signal) begin
         state_r     <= ST_IDLE;
         tmr_r       <= 32'd0;
         abort_r     <= 1'b0;
         fsm_start_r <= 1'b0;
         fsm_reset_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r <= next_state_s;
         if (tmr_clr_s) begin
            tmr_r <= 32'd0;
         end else if (tmr_r != TMR_MAX) begin
            tmr_r <= tmr_r + 32'd1;
         end else begin
            tmr_r <= tmr_r;
         end
         if (abort_go_s) begin
            abort_r <= 1'b1;
         end else if (next_state_s != ST_RECOVER) begin
            abort_r <= 1'b0;
         end else if (abort) begin
            abort_r <= 1'b1;
         end else begin
            abort_r <= abort_r;
         end
         fsm_start_r <= (next_state_s == ST_START) || (next_state_s == ST_RUN);
         fsm_reset_r <= (next_state_s == ST_RECOVER);
         busy_r      <= (next_state_s != ST_IDLE);
         done_r      <= (next_state_s == ST_DONE);
      end
   end

   // Series configuration latch and shot/failure accounting; values hold after DONE.
   always_ff @(posedge clock) begin
      if (!reset_signal) begin
         shot_cfg_r   <= {CNT_W{1'b0}};
         cd_lim_r     <= 32'd0;
         wd_lim_r     <= 32'd0;
         shots_done_r <= {CNT_W{1'b0}};
         fail_count_r <= {CNT_W{1'b0}};
         error_r      <= 1'b0;
      end else if (cfg_load_s) begin
         shot_cfg_r   <= shot_count;
         cd_lim_r     <= cooldown;
         wd_lim_r     <= watchdog;
         shots_done_r <= {CNT_W{1'b0}};
         fail_count_r <= {CNT_W{1'b0}};
         error_r      <= 1'b0;
      end else begin
         if (consume_s) begin
            shots_done_r <= sat_inc(shots_done_r);
         end
         if (shot_fail_s) begin
            fail_count_r <= sat_inc(fail_count_r);
         end
         if (shot_fail_s || abort_go_s) begin
            error_r <= 1'b1;
         end
      end
   end

   assign fsm_start  = fsm_start_r;
   assign fsm_reset  = fsm_reset_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign error      = error_r;
   assign shots_done = shots_done_r;
   assign fail_count = fail_count_r;
   assign seq_state  = state_r;

endmodule

// File: tb/tb_experiment_sequencer.sv
// Self-checking bench for experiment_sequencer: behavioural experiment-FSM model, a table of
// series with expected results queued at arm and compared at done, plus hand-written corners.
module tb_experiment_sequencer;

   localparam logic [7:0] FIN = 8'd8;

   logic        clock = 1'b0;
   logic        reset_signal = 1'b0;
   logic        arm = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] shot_count = 16'd0;
   logic [31:0] cooldown = 32'd0;
   logic [31:0] watchdog = 32'd0;
   logic [7:0]  fsm_state = 8'd0;
   logic        fsm_start, fsm_reset, busy, done, error;
   logic [15:0] shots_done, fail_count;
   logic [2:0]  seq_state;

   experiment_sequencer #(.CNT_W(16), .FIN_CODE(8), .RESET_HOLD(4), .MAX_RETRY(3)) dut (
      .clock(clock), .reset_signal(reset_signal), .arm(arm), .abort(abort),
      .shot_count(shot_count), .cooldown(cooldown), .watchdog(watchdog),
      .fsm_state(fsm_state), .fsm_start(fsm_start), .fsm_reset(fsm_reset),
      .busy(busy), .done(done), .error(error), .shots_done(shots_done),
      .fail_count(fail_count), .seq_state(seq_state)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] sc;
      logic [31:0] cd;
      logic [31:0] wd;
      int mode;        // 0: shot finishes after 50 cycles, 1: FSM hangs at state 2
      int abort_cyc;   // cycle after arm at which abort is raised for one cycle, 0 = never
      int exp_shots, exp_fail, exp_err, exp_starts, exp_resets, exp_start_len, exp_gap;
   } row_t;

   typedef struct {
      int shots;
      int fail;
      int err;
   } exp_t;

   row_t rows[5];
   exp_t sb[$];
   int total = 0;
   int bad = 0;
   int model_mode = 0;
   int m_cnt = 0;
   logic m_rst_prev = 1'b0;

   task automatic chk(input string name, input int act, input int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   // Experiment FSM model: leaves 0 on start, finishes (or hangs), returns to 0 on release/reset.
   always @(negedge clock) begin
      if (!reset_signal || (fsm_reset && !m_rst_prev)) begin
         fsm_state = 8'd0;
         m_cnt = 0;
      end else if (fsm_state == 8'd0) begin
         if (fsm_start) begin
            fsm_state = (model_mode == 1) ? 8'd2 : 8'd1;
            m_cnt = 1;
         end
      end else if (fsm_state == FIN) begin
         if (!fsm_start) fsm_state = 8'd0;
      end else if (model_mode == 0) begin
         m_cnt++;
      end
      if (model_mode == 0 && fsm_state == 8'd1 && m_cnt >= 50) fsm_state = FIN;
      m_rst_prev = fsm_reset;
   end

   task automatic run_row(input int idx, input row_t r);
      exp_t e;
      int n_starts = 0, n_resets = 0, rst_bad = 0, start_len = 0, max_start = 0;
      int low_len = 0, last_gap = 0, rst_len = 0, seen = 0;
      logic prev_start = 1'b0, prev_rst = 1'b0;
      @(negedge clock);
      model_mode = r.mode;
      shot_count = r.sc;
      cooldown = r.cd;
      watchdog = r.wd;
      arm = 1'b1;
      sb.push_back('{shots: r.exp_shots, fail: r.exp_fail, err: r.exp_err});
      for (int c = 1; c <= 3000 && seen == 0; c++) begin
         @(negedge clock);
         arm = 1'b0;
         abort = (r.abort_cyc != 0) && (c == r.abort_cyc);
         if (r.abort_cyc != 0 && c == r.abort_cyc + 1) begin
            chk($sformatf("row%0d start_drops_on_abort", idx), int'(fsm_start), 0);
            chk($sformatf("row%0d reset_after_abort", idx), int'(fsm_reset), 1);
         end
         if (fsm_start) begin
            if (!prev_start) begin
               if (n_starts > 0) last_gap = low_len;
               n_starts++;
               start_len = 0;
            end
            start_len++;
            if (start_len > max_start) max_start = start_len;
         end else begin
            if (prev_start) low_len = 0;
            low_len++;
         end
         prev_start = fsm_start;
         if (fsm_reset) begin
            rst_len++;
         end else if (prev_rst) begin
            n_resets++;
            if (rst_len != 4) rst_bad++;
            rst_len = 0;
         end
         prev_rst = fsm_reset;
         if (done) begin
            seen = 1;
            e = sb.pop_front();
            chk($sformatf("row%0d shots_done", idx), int'(shots_done), e.shots);
            chk($sformatf("row%0d fail_count", idx), int'(fail_count), e.fail);
            chk($sformatf("row%0d error", idx), int'(error), e.err);
            chk($sformatf("row%0d seq_state_at_done", idx), int'(seq_state), 6);
            chk($sformatf("row%0d busy_at_done", idx), int'(busy), 1);
         end
      end
      chk($sformatf("row%0d done_seen", idx), seen, 1);
      if (seen == 0 && sb.size() != 0) e = sb.pop_front();
      chk($sformatf("row%0d start_pulses", idx), n_starts, r.exp_starts);
      chk($sformatf("row%0d reset_pulses", idx), n_resets, r.exp_resets);
      chk($sformatf("row%0d reset_len_bad", idx), rst_bad, 0);
      chk($sformatf("row%0d start_len", idx), max_start, r.exp_start_len);
      chk($sformatf("row%0d start_gap", idx), last_gap, r.exp_gap);
      @(negedge clock);
      chk($sformatf("row%0d idle_after_done", idx), int'({busy, done, seq_state}), 0);
   endtask

   initial begin
      rows[0] = '{16'd3, 32'd10, 32'd0,   0, 0,  3, 0, 0, 3, 0, 50, 11};
`ifdef RETRY_EN
      rows[1] = '{16'd2, 32'd5,  32'd100, 1, 0,  0, 4, 1, 4, 4, 100, 9};
`else
      rows[1] = '{16'd2, 32'd5,  32'd100, 1, 0,  2, 2, 1, 2, 2, 100, 9};
`endif
      rows[2] = '{16'd1, 32'd0,  32'd50,  0, 0,  1, 0, 0, 1, 0, 50, 0};
      rows[3] = '{16'd5, 32'd3,  32'd0,   0, 20, 0, 0, 1, 1, 1, 20, 0};
      rows[4] = '{16'd2, 32'd0,  32'd60,  0, 0,  2, 0, 0, 2, 0, 50, 2};

      // reset state
      repeat (3) @(negedge clock);
      chk("rst fsm_start", int'(fsm_start), 0);
      chk("rst fsm_reset", int'(fsm_reset), 0);
      chk("rst busy_done_error", int'({busy, done, error}), 0);
      chk("rst counters", int'({shots_done, fail_count}), 0);
      chk("rst seq_state", int'(seq_state), 0);
      reset_signal = 1'b1;

      for (int i = 0; i < 5; i++) run_row(i, rows[i]);

      // arm with shot_count == 0: one-cycle busy/done, no start, counters hold
      @(negedge clock);
      shot_count = 16'd0;
      arm = 1'b1;
      @(negedge clock);
      arm = 1'b0;
      chk("zero done", int'(done), 1);
      chk("zero busy", int'(busy), 1);
      chk("zero no_start", int'(fsm_start), 0);
      chk("zero counters_hold", int'(shots_done), 2);
      @(negedge clock);
      chk("zero busy_gone", int'({busy, done, fsm_start}), 0);

      // abort while IDLE is ignored
      abort = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("idle_abort state", int'({busy, seq_state}), 0);
         chk("idle_abort error", int'(error), 0);
      end
      abort = 1'b0;

      // reset mid-RUN, with arm held while reset is low
      @(negedge clock);
      model_mode = 0;
      shot_count = 16'd3;
      cooldown = 32'd10;
      watchdog = 32'd0;
      arm = 1'b1;
      @(negedge clock);
      arm = 1'b0;
      repeat (10) @(negedge clock);
      chk("midrun in_run", int'(seq_state), 2);
      reset_signal = 1'b0;
      arm = 1'b1;
      @(negedge clock);
      chk("midrun outputs", int'({fsm_start, fsm_reset, busy, done, error}), 0);
      chk("midrun counters", int'({shots_done, fail_count}), 0);
      chk("midrun seq_state", int'(seq_state), 0);
      repeat (2) begin
         @(negedge clock);
         chk("midrun arm_ignored", int'({busy, seq_state, fsm_start}), 0);
      end
      reset_signal = 1'b1;
      arm = 1'b0;
      @(negedge clock);
      chk("midrun post_release", int'({busy, seq_state}), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
